sync_load_up_counter: RTL and testbench
=======================================

Name: sync_load_up_counter

Overview:
- Free-running binary up counter with synchronous parallel load and asynchronous reset.
- Generic utility block for datapath and control: timers, address generators, sequence indices.
- Single clock domain. Output `count` is driven directly from a register.

Parameters:
- WIDTH, 4, counter and load-data width in bits; legal range 1..32.
- RESET_VALUE, 0, value `count` takes while `rst` is asserted; truncated to WIDTH bits.

Ports:
- clk    input   1      rising-edge clock
- rst    input   1      asynchronous, active-high reset
- load   input   1      synchronous load strobe; samples d_in at the next rising clk edge
- d_in   input   WIDTH  parallel load value
- count  output  WIDTH  current counter value, registered

Behaviour:
- Reset: while `rst`=1, count = RESET_VALUE (default 0).
  - Reset takes effect immediately, with no clock edge needed, and holds regardless of `clk`, `load` and `d_in`.
  - Deassertion is synchronised by the system; the first edge with `rst`=0 performs normal operation.
- Priority at each rising `clk` edge: `rst` > `load` > increment.
  - If `load`=1, count <= d_in.
  - Otherwise count <= count + 1, modulo 2^WIDTH.
- The counter has no enable and no hold state. It increments on every non-load cycle.
- Latency:
  - A load is visible on `count` one cycle after the sampling edge.
  - After a load, the following edges produce d_in+1, d_in+2, and so on.
- Wrap-around: all-ones + 1 = 0. No saturation and no error flag, except the optional tc below.
- Back-to-back loads: each edge with `load`=1 overwrites `count` with the current d_in. No increment occurs between loads.
- Loading all-ones: count = all-ones for one cycle, then wraps to 0.
- d_in is ignored when `load`=0. X or Z on d_in while `load`=0 must not affect `count`.
- Reset mid-operation:
  - Asserting `rst` in the middle of a cycle overrides a pending load or increment immediately.
  - A load asserted on the same edge that `rst` is high is discarded.
- `count` is glitch-free: single register, no combinational path from inputs to `count`.

Optional Feature:
- Macro: SYNC_LOAD_UP_COUNTER_TC_EN.
- When defined, the block adds output port `tc`, 1 bit, terminal count:
  - `tc` = 1 when count == all-ones, combinational decode of the count register only.
  - `tc` is low during reset unless RESET_VALUE is all-ones.
  - `tc` is 1 during the cycle before a wrap. When `load`=1 in that cycle, no wrap occurs, but `tc` still reflects the current count.
- When undefined, `tc` is absent, with no extra logic and an identical port list otherwise.

Decomposition:
- Package `sync_load_up_counter_pkg` holds:
  - localparam DEFAULT_WIDTH = 4 and DEFAULT_RESET_VALUE = 0;
  - a function max_count(width) returning all-ones, used by the tc decode and the testbench.
- No sub-module. Next-state mux (load/increment) and register live in one always block. The tc decode is a single continuous assignment.

Test Plan:
- Reset then free-run: assert `rst` for one cycle with load=0, release, wait 4 edges -> count = 0 during reset, then 1, 2, 3, 4.
- Load mid-count: load=1, d_in=4'b1010 for one edge -> count=1010 next cycle, then 1011, 1100, 1101, 1110 on the following edges with load=0.
- Second load and wrap: load d_in=4'b0011 -> 0011, then increments. Separately, load 4'b1110 -> 1110, 1111, 0000, 0001, with tc=1 only during 1111 when SYNC_LOAD_UP_COUNTER_TC_EN is defined.
- Async reset: assert `rst` between clock edges while count=0111 -> count=0000 before the next rising edge. Hold `rst` with load=1, d_in=1010 across two edges -> count stays 0000.
- Back-to-back loads: load held high for 3 edges with d_in = 0101, 1001, 1111 -> count follows 0101, 1001, 1111. Release load -> 0000.
- Don't-care input: load=0, d_in toggled randomly or set to X -> count increments normally by 1 per edge.

Source files
------------

// File: rtl/sync_load_up_counter_pkg.sv
// Shared constants and helpers for sync_load_up_counter.
// max_count() gives the all-ones terminal value used by the tc decode and the bench.
package sync_load_up_counter_pkg;

  localparam int unsigned DEFAULT_WIDTH       = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_VALUE = 32'd0;

  function automatic logic [31:0] max_count(input int unsigned width);
    logic [31:0] ones_s;
    if (width >= 32'd32) begin
      ones_s = 32'hFFFF_FFFF;
    end else begin
      ones_s = (32'd1 << width) - 32'd1;
    end
    return ones_s;
  endfunction

endpackage

// File: rtl/sync_load_up_counter.sv
// Free-running up counter with synchronous parallel load and asynchronous reset.
// Define SYNC_LOAD_UP_COUNTER_TC_EN to add the terminal-count output tc.
module sync_load_up_counter
  import sync_load_up_counter_pkg::*;
#(
  parameter int unsigned WIDTH       = DEFAULT_WIDTH,
  parameter logic [31:0] RESET_VALUE = DEFAULT_RESET_VALUE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] count
`ifdef SYNC_LOAD_UP_COUNTER_TC_EN
  ,
  output logic             tc
`endif
);

  localparam logic [WIDTH-1:0] RST_VAL = RESET_VALUE[WIDTH-1:0];
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  logic [WIDTH-1:0] count_r;

  // Counter register: reset dominates, then load, otherwise wrap-around increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= RST_VAL;
    end else if (load) begin
      count_r <= d_in;
    end else begin
      count_r <= count_r + ONE;
    end
  end

  assign count = count_r;

`ifdef SYNC_LOAD_UP_COUNTER_TC_EN
  localparam logic [WIDTH-1:0] MAX_COUNT = WIDTH'(max_count(WIDTH));

  // Decoded from the register only, so tc never depends on load or d_in.
  assign tc = (count_r == MAX_COUNT);
`endif

endmodule

// File: tb/tb_sync_load_up_counter.sv
// Self-checking bench for sync_load_up_counter: directed cases plus randomized
// load/reset traffic checked against an arithmetic reference model.
module tb_sync_load_up_counter;
  import sync_load_up_counter_pkg::*;

  localparam int unsigned W   = 32'd4;
  localparam int          MOD = 1 << W;

  logic         clk;
  logic         rst;
  logic         load;
  logic [W-1:0] d_in;
  logic [W-1:0] count;
`ifdef SYNC_LOAD_UP_COUNTER_TC_EN
  logic         tc;
`endif

  int checks   = 0;
  int failures = 0;
  int exp_cnt  = 0;

  sync_load_up_counter #(.WIDTH(W), .RESET_VALUE(32'd0)) dut (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .d_in  (d_in),
    .count (count)
`ifdef SYNC_LOAD_UP_COUNTER_TC_EN
    ,
    .tc    (tc)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_state(input string tag);
    check_eq({tag, "_count"}, int'(count), exp_cnt);
`ifdef SYNC_LOAD_UP_COUNTER_TC_EN
    check_eq({tag, "_tc"}, int'(tc), (exp_cnt == int'(max_count(W))) ? 1 : 0);
`endif
  endtask

  // One clock edge: model applies reset > load > increment, then compare 1 ns later.
  task automatic cycle(input string tag, input logic ld, input logic [W-1:0] d);
    load = ld;
    d_in = d;
    @(posedge clk);
    if (rst)     exp_cnt = 0;
    else if (ld) exp_cnt = int'(d);
    else         exp_cnt = (exp_cnt + 1) % MOD;
    #1;
    check_state(tag);
    @(negedge clk);
  endtask

  // Assert reset between edges; count must clear without a clock edge.
  task automatic async_reset(input string tag);
    #2;
    rst = 1'b1;
    exp_cnt = 0;
    #1;
    check_state(tag);
  endtask

  initial begin
    rst  = 1'b1;
    load = 1'b0;
    d_in = 4'b0000;
    #1;
    check_state("reset_async");
    cycle("reset_hold", 1'b0, 4'b0000);
    rst = 1'b0;

    for (int i = 0; i < 4; i++) cycle("free_run", 1'b0, 4'b0000);

    cycle("load_1010", 1'b1, 4'b1010);
    for (int i = 0; i < 4; i++) cycle("after_1010", 1'b0, 4'b0000);

    cycle("load_0011", 1'b1, 4'b0011);
    for (int i = 0; i < 2; i++) cycle("after_0011", 1'b0, 4'b0000);

    cycle("load_1110", 1'b1, 4'b1110);
    for (int i = 0; i < 3; i++) cycle("wrap", 1'b0, 4'b0000);

    // tc high at all-ones while a load suppresses the wrap
    cycle("load_1111", 1'b1, 4'b1111);
    cycle("load_over_tc", 1'b1, 4'b0010);

    cycle("load_0110", 1'b1, 4'b0110);
    cycle("to_0111", 1'b0, 4'b0000);
    async_reset("async_rst");
    cycle("rst_vs_load", 1'b1, 4'b1010);
    cycle("rst_vs_load", 1'b1, 4'b1010);
    rst = 1'b0;
    cycle("post_rst", 1'b0, 4'b0000);

    cycle("b2b", 1'b1, 4'b0101);
    cycle("b2b", 1'b1, 4'b1001);
    cycle("b2b", 1'b1, 4'b1111);
    cycle("b2b_release", 1'b0, 4'b0000);

    for (int i = 0; i < 6; i++) cycle("din_x", 1'b0, 4'bxxxx);
    for (int i = 0; i < 6; i++) cycle("din_rand", 1'b0, 4'($urandom));

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 24) == 0) begin
        async_reset("rand_rst");
        cycle("rand_rst_edge", 1'($urandom), 4'($urandom));
        rst = 1'b0;
      end else if ($urandom_range(0, 3) == 0) begin
        cycle("rand_load", 1'b1, 4'($urandom));
      end else begin
        cycle("rand_inc", 1'b0, ($urandom_range(0, 1) == 0) ? 4'bxxxx : 4'($urandom));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
